// File: rtl/row_clear_engine.sv
// row_clear_engine: sequential line-clear pass run after a piece locks.
// Scans the stacked board bottom-to-top, removes every full row, shifts the
// rows above it down by one, and reports the compacted board, the number of
// rows removed and whether the spawn row is still occupied.
//
// Handshake: start is a one-cycle request taken only while idle (busy=0);
// busy stays high from the cycle after acceptance up to and including the
// single-cycle done pulse, and board_out/lines_cleared/game_over are valid
// from the done cycle and held until the next done.
module row_clear_engine #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int CNT_W   = $clog2(BOARD_H + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BOARD_W*BOARD_H-1:0] board_in,
    output logic                       busy,
    output logic                       done,
    output logic [BOARD_W*BOARD_H-1:0] board_out,
    output logic [CNT_W-1:0]           lines_cleared,
    output logic                       game_over
);

    localparam int N     = BOARD_W * BOARD_H;
    localparam int PTR_W = $clog2(BOARD_H);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [N-1:0]       r_work;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_done;
    logic [N-1:0]       r_board_out;
    logic [CNT_W-1:0]   r_lines;
    logic               r_game_over;

    logic [BOARD_W-1:0] w_row_sel;
    logic               w_row_full;
    logic [N-1:0]       w_shifted;

    // Select the work row addressed by the scan pointer.
    always_comb begin
        w_row_sel = '0;
        for (int r = 0; r < BOARD_H; r++) begin
            if (r_ptr == PTR_W'(r)) begin
                w_row_sel = r_work[r*BOARD_W +: BOARD_W];
            end
        end
    end

    assign w_row_full = &w_row_sel;

    // Drop every row at or above the pointer by one; the top row fills with zeros.
    always_comb begin
        w_shifted = r_work;
        w_shifted[BOARD_W-1:0] = '0;
        for (int r = 1; r < BOARD_H; r++) begin
            if (PTR_W'(r) <= r_ptr) begin
                w_shifted[r*BOARD_W +: BOARD_W] = r_work[(r-1)*BOARD_W +: BOARD_W];
            end
        end
    end

    // Main FSM: capture, scan/shift loop, and output latch on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_ptr       <= '0;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_board_out <= '0;
            r_lines     <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work  <= board_in;
                        r_ptr   <= PTR_W'(BOARD_H - 1);
                        r_count <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_row_full) begin
                        r_state <= S_SHIFT;
                    end else if (r_ptr == '0) begin
                        // Outputs are latched here so they are valid in the done cycle.
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_board_out <= r_work;
                        r_lines     <= r_count;
                        r_game_over <= |r_work[BOARD_W-1:0];
                    end else begin
                        r_ptr <= r_ptr - 1'b1;
                    end
                end
                S_SHIFT: begin
                    // Pointer is left alone so the row just moved in is re-tested.
                    r_work  <= w_shifted;
                    r_count <= r_count + 1'b1;
                    r_state <= S_SCAN;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign board_out     = r_board_out;
    assign lines_cleared = r_lines;
    assign game_over     = r_game_over;

endmodule

// File: tb/tb_row_clear_engine.sv
// Directed bench for row_clear_engine with a scoreboard of expected runs.
module tb_row_clear_engine;

  localparam int W = 10;
  localparam int H = 20;
  localparam int N = W * H;
  localparam int CW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  board_in;
  logic          busy;
  logic          done;
  logic [N-1:0]  board_out;
  logic [CW-1:0] lines_cleared;
  logic          game_over;

  row_clear_engine #(.BOARD_W(W), .BOARD_H(H), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .board_in(board_in),
    .busy(busy), .done(done), .board_out(board_out),
    .lines_cleared(lines_cleared), .game_over(game_over)
  );

  typedef struct {
    logic [N-1:0] board;
    int           lines;
    logic         go;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] row_mask(input int r);
    logic [N-1:0] m;
    m = '0;
    m[r*W +: W] = '1;
    return m;
  endfunction

  // Reference compaction: keep non-full rows, packed downward in order.
  function automatic logic [N-1:0] compact(input logic [N-1:0] b, output int lines);
    logic [N-1:0] res;
    logic [W-1:0] row;
    int dst;
    res = '0;
    lines = 0;
    dst = H - 1;
    for (int src = H - 1; src >= 0; src--) begin
      row = b[src*W +: W];
      if (&row) lines++;
      else begin
        res[dst*W +: W] = row;
        dst--;
      end
    end
    return res;
  endfunction

  // scoreboard: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("board_out", board_out, e.board);
        chk("lines_cleared", N'(lines_cleared), N'(e.lines));
        chk("game_over", N'(game_over), N'(e.go));
        chk("done_cycle", N'(cyc), N'(e.cyc));
        chk("busy_in_done", N'(busy), N'(1));
      end
    end
  end

  // driver: one-cycle start pulse, expectation pushed with the start
  task automatic kick(input logic [N-1:0] b, input logic [N-1:0] eb, input int el, input logic eg);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    board_in = b;
    e.board = eb;
    e.lines = el;
    e.go = eg;
    e.cyc = cyc + 1 + H + 2 * el;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    board_in = {7{$urandom()}};
  endtask

  task automatic kick_model(input logic [N-1:0] b);
    int l;
    logic [N-1:0] eb;
    eb = compact(b, l);
    kick(b, eb, l, |eb[W-1:0]);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(tag, N'(exp_q.size()), N'(0));
    exp_q.delete();
    @(negedge clk);
    chk({tag, "_idle"}, N'(busy), N'(0));
  endtask

  initial begin
    logic [N-1:0] b;
    rst = 1'b1;
    start = 1'b0;
    board_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", N'(busy), N'(0));
    chk("reset_done", N'(done), N'(0));
    chk("reset_board", board_out, '0);
    chk("reset_lines", N'(lines_cleared), N'(0));
    chk("reset_go", N'(game_over), N'(0));
    rst = 1'b0;

    // 1: empty board
    kick('0, '0, 0, 1'b0);
    @(negedge clk);
    chk("t1_busy_mid", N'(busy), N'(1));
    wait_drain("t1_timeout");

    // 2: row 19 full + (18,3)
    b = row_mask(19);
    b[183] = 1'b1;
    begin
      logic [N-1:0] e;
      e = '0;
      e[193] = 1'b1;
      kick(b, e, 1, 1'b0);
      wait_drain("t2_timeout");

      // 3: rows 17 and 19 full + (18,0)
      b = row_mask(17) | row_mask(19);
      b[180] = 1'b1;
      e = '0;
      e[190] = 1'b1;
      kick(b, e, 2, 1'b0);
      wait_drain("t3_timeout");
    end

    // 4: bottom four rows full, then all ones
    kick(row_mask(16) | row_mask(17) | row_mask(18) | row_mask(19), '0, 4, 1'b0);
    wait_drain("t4a_timeout");
    kick('1, '0, 20, 1'b0);
    wait_drain("t4b_timeout");

    // 5: spawn-row block, extra start mid-run must be ignored
    b = '0;
    b[4] = 1'b1;
    kick(b, b, 0, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    start = 1'b1;
    board_in = '1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("t5_timeout");
    repeat (30) @(negedge clk);

    // random boards checked against the reference compaction
    for (int k = 0; k < 4; k++) begin
      b = '0;
      for (int r = 0; r < H; r++) begin
        if ($urandom_range(0, 2) == 0) b[r*W +: W] = '1;
        else if (r >= 8) b[r*W +: W] = W'($urandom_range(0, 1022));
      end
      kick_model(b);
      wait_drain("rand_timeout");
    end

    // 6: reset mid-run
    @(posedge clk); #1;
    start = 1'b1;
    board_in = row_mask(19);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_busy", N'(busy), N'(0));
    chk("t6_rst_done", N'(done), N'(0));
    chk("t6_rst_board", board_out, '0);
    chk("t6_rst_lines", N'(lines_cleared), N'(0));
    chk("t6_rst_go", N'(game_over), N'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    kick(row_mask(19), '0, 1, 1'b0);
    wait_drain("t6_timeout");
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
